// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Feature macro LSU_MISALIGN_TRAP_EN is consumed by load_store_unit.sv.
package lsu_pkg;

    // RISC-V load/store width encodings (funct3).
    typedef enum logic [2:0] {
        F3B  = 3'b000,
        F3H  = 3'b001,
        F3W  = 3'b010,
        F3BU = 3'b100,
        F3HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWrite,
        StDone
    } lsu_state_e;

    // Byte-lane offsets within a 32-bit word.
    localparam logic [1:0] Lane0 = 2'd0;
    localparam logic [1:0] Lane1 = 2'd1;
    localparam logic [1:0] Lane2 = 2'd2;
    localparam logic [1:0] Lane3 = 2'd3;

    // Replace the addressed byte or halfword lane of word with the low bits of wdata.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  off,
                                                input logic        half);
        logic [31:0] res;
        res = word;
        if (half) begin
            if (off[1]) res[31:16] = wdata[15:0];
            else        res[15:0]  = wdata[15:0];
        end else begin
            unique case (off)
                Lane0: res[7:0]   = wdata[7:0];
                Lane1: res[15:8]  = wdata[7:0];
                Lane2: res[23:16] = wdata[7:0];
                Lane3: res[31:24] = wdata[7:0];
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: selects the addressed byte/halfword of the
// read word and sign- or zero-extends it to 32 bits.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by width-dependent extension.
    always_comb begin
        byte_sel = word_i[7:0];
        unique case (offset_i)
            Lane0: byte_sel = word_i[7:0];
            Lane1: byte_sel = word_i[15:8];
            Lane2: byte_sel = word_i[23:16];
            Lane3: byte_sel = word_i[31:24];
        endcase
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            F3B:     data_o = {{24{byte_sel[7]}}, byte_sel};
            F3BU:    data_o = {24'h0, byte_sel};
            F3H:     data_o = {{16{half_sel[15]}}, half_sel};
            F3HU:    data_o = {16'h0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-organised RAM with combinational
// read. Sub-word stores are a read-modify-write through a merge register.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (report misaligned/illegal
// accesses via resp_err instead of silently aligning them).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     resp_valid,
    output logic [31:0]              resp_rdata,
    output logic                     resp_err,
    output logic                     MemWrite,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [31:0]              write_data,
    input  logic [31:0]              read_data
);

    localparam int unsigned AW = $clog2(DEPTH);

    lsu_state_e    state_q, state_d;
    logic          we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   merge_q, merge_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          req_illegal;
    logic          req_misalign;
    logic [2:0]    f3_norm;
    logic [AW+1:0] addr_norm;
    logic [31:0]   load_data;

    // Address bits above the RAM size are dropped so accesses wrap.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:AW+2];

    // Classify the incoming request and normalise width/alignment.
    always_comb begin
        if (req_we) req_illegal = (req_funct3 == 3'b011) || req_funct3[2];
        else        req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        f3_norm      = req_illegal ? F3W : req_funct3;
        addr_norm    = req_addr[AW+1:0];
        req_misalign = 1'b0;
        case (f3_norm)
            F3H, F3HU: begin
                req_misalign = req_addr[0];
                addr_norm[0] = 1'b0;
            end
            F3W: begin
                req_misalign   = |req_addr[1:0];
                addr_norm[1:0] = 2'b00;
            end
            default: ;
        endcase
    end

`ifndef LSU_MISALIGN_TRAP_EN
    logic unused_misalign;
    assign unused_misalign = req_misalign;
`endif

    lsu_load_align u_load_align (
        .word_i   (read_data),
        .offset_i (addr_q[1:0]),
        .funct3_i (f3_q),
        .data_o   (load_data)
    );

    // Next-state and datapath latching for the access FSM.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = f3_norm;
                    addr_d  = addr_norm;
                    wdata_d = req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (req_illegal || req_misalign) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StAccess;
                    end
`else
                    state_d = StAccess;
`endif
                end
            end
            StAccess: begin
                err_d = 1'b0;
                if (!we_q) begin
                    rdata_d = load_data;
                    state_d = StDone;
                end else if (f3_q == F3W) begin
                    rdata_d = '0;
                    state_d = StDone;
                end else begin
                    rdata_d = '0;
                    merge_d = store_merge(read_data, wdata_q, addr_q[1:0], f3_q == F3H);
                    state_d = StWrite;
                end
            end
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from registered state; the RAM is only written in a
    // word-store ACCESS or in WRITE, so reset drops MemWrite at once.
    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StDone);
        resp_rdata = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        resp_err   = err_q;
`else
        resp_err   = 1'b0;
`endif
        MemWrite   = (state_q == StWrite) ||
                     ((state_q == StAccess) && we_q && (f3_q == F3W));
        mem_addr   = addr_q[AW+1:2];
        write_data = (state_q == StWrite) ? merge_q : wdata_q;
    end

`ifndef LSU_MISALIGN_TRAP_EN
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural RAM and a response
// scoreboard. Expectations adapt to LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          req_valid, req_ready, req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr, req_wdata;
    logic          resp_valid, resp_err, MemWrite;
    logic [31:0]   resp_rdata, write_data, read_data;
    logic [AW-1:0] mem_addr;

    logic [31:0]   ram [DEPTH];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;
    resp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    int            wc, wl;
    logic [AW-1:0] wa;
    resp_t         want;

    load_store_unit #(.DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .MemWrite   (MemWrite),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data)
    );

    always #5 CLK = ~CLK;

    assign read_data = ram[mem_addr];

    always @(posedge CLK) begin
        if (MemWrite)   ram[mem_addr] <= write_data;
        else if (pl_en) ram[pl_addr]  <= pl_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge CLK);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge CLK); #1;
        pl_en = 1'b0;
    endtask

    // One complete access: drive, wait (bounded) for the response, score it.
    task automatic run_access(input string tag, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] exp_rd, input logic exp_err,
                              input int exp_lat, output int wr_cnt, output int wr_lat,
                              output logic [AW-1:0] wr_addr);
        resp_t w;
        int    lat;
        bit    seen;
        @(negedge CLK);
        for (int i = 0; i < 16 && !req_ready; i++) @(negedge CLK);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        exp_q.push_back('{rdata: exp_rd, err: exp_err});
        @(posedge CLK); #1;
        req_valid = 1'b0;
        lat = 1; seen = 0; wr_cnt = 0; wr_lat = 0; wr_addr = '0;
        for (int i = 0; i < 8; i++) begin
            if (MemWrite) begin
                wr_cnt++;
                wr_lat  = lat;
                wr_addr = mem_addr;
            end
            if (resp_valid) begin
                seen = 1;
                break;
            end
            @(posedge CLK); #1;
            lat++;
        end
        check({tag, " resp_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        w = exp_q.pop_front();
        check({tag, " rdata"}, resp_rdata, w.rdata);
        check({tag, " err"}, 32'(resp_err), 32'(w.err));
        @(posedge CLK); #1;
        check({tag, " pulse_end"}, 32'(resp_valid), 32'd0);
        check({tag, " rdata_hold"}, resp_rdata, w.rdata);
    endtask

    initial begin
        RST_N = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        check("reset resp_err", 32'(resp_err), 32'd0);
        check("reset MemWrite", 32'(MemWrite), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset write_data", write_data, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Word store then load.
        run_access("sw", 1'b1, F3W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, wc, wl, wa);
        check("sw write_count", 32'(wc), 32'd1);
        check("sw write_cycle", 32'(wl), 32'd1);
        check("sw mem_addr", 32'(wa), 32'd4);
        check("sw ram", ram[4], 32'hDEADBEEF);
        run_access("lw", 1'b0, F3W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, wc, wl, wa);
        check("lw write_count", 32'(wc), 32'd0);

        // Byte read-modify-write.
        preload(8, 32'h11223344);
        run_access("sb", 1'b1, F3B, 32'h21, 32'h000000AA, 32'h0, 1'b0, 3, wc, wl, wa);
        check("sb write_count", 32'(wc), 32'd1);
        check("sb write_cycle", 32'(wl), 32'd2);
        check("sb ram", ram[8], 32'h1122AA44);

        // Sign and zero extension.
        preload(12, 32'h8000FF80);
        run_access("lb", 1'b0, F3B, 32'h30, 32'h0, 32'hFFFFFF80, 1'b0, 2, wc, wl, wa);
        run_access("lbu", 1'b0, F3BU, 32'h30, 32'h0, 32'h00000080, 1'b0, 2, wc, wl, wa);
        run_access("lh", 1'b0, F3H, 32'h32, 32'h0, 32'hFFFF8000, 1'b0, 2, wc, wl, wa);
        run_access("lhu", 1'b0, F3HU, 32'h32, 32'h0, 32'h00008000, 1'b0, 2, wc, wl, wa);
        run_access("lb_lane1", 1'b0, F3B, 32'h31, 32'h0, 32'hFFFFFFFF, 1'b0, 2, wc, wl, wa);

        // Misaligned and illegal accesses.
        preload(16, 32'h89ABCDEF);
`ifdef LSU_MISALIGN_TRAP_EN
        run_access("lh_mis", 1'b0, F3H, 32'h41, 32'h0, 32'h0, 1'b1, 1, wc, wl, wa);
        check("lh_mis write_count", 32'(wc), 32'd0);
        run_access("ld_ill", 1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1'b1, 1, wc, wl, wa);
        run_access("sh_mis", 1'b1, F3H, 32'h43, 32'h1111, 32'h0, 1'b1, 1, wc, wl, wa);
        check("sh_mis write_count", 32'(wc), 32'd0);
        check("sh_mis ram", ram[16], 32'h89ABCDEF);
`else
        run_access("lh_mis", 1'b0, F3H, 32'h41, 32'h0, 32'hFFFFCDEF, 1'b0, 2, wc, wl, wa);
        check("lh_mis write_count", 32'(wc), 32'd0);
        run_access("ld_ill", 1'b0, 3'b011, 32'h40, 32'h0, 32'h89ABCDEF, 1'b0, 2, wc, wl, wa);
        run_access("sh_mis", 1'b1, F3H, 32'h43, 32'h1111, 32'h0, 1'b0, 3, wc, wl, wa);
        check("sh_mis write_count", 32'(wc), 32'd1);
        check("sh_mis ram", ram[16], 32'h1111CDEF);
`endif

        // Halfword RMW through a wrapped address (0x1012 -> word 4).
        run_access("sh_wrap", 1'b1, F3H, 32'h1012, 32'hFFFF1234, 32'h0, 1'b0, 3, wc, wl, wa);
        check("sh_wrap mem_addr", 32'(wa), 32'd4);
        check("sh_wrap ram", ram[4], 32'h1234BEEF);

        // Reset asserted during WRITE of a halfword store.
        preload(20, 32'hCAFEF00D);
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3H;
        req_addr = 32'h52; req_wdata = 32'h0000BEEF;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        check("rst access MemWrite", 32'(MemWrite), 32'd0);
        @(posedge CLK); #1;
        check("rst write MemWrite", 32'(MemWrite), 32'd1);
        #1 RST_N = 1'b0;
        #1;
        check("rst async MemWrite", 32'(MemWrite), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("rst ram unchanged", ram[20], 32'hCAFEF00D);
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst resp_valid", 32'(resp_valid), 32'd0);

        // Back-pressure: requests while busy are ignored; one held through
        // DONE is taken in the next IDLE cycle.
        preload(32, 32'h0);
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3W; req_addr = 32'h10; req_wdata = '0;
        exp_q.push_back('{rdata: 32'h1234BEEF, err: 1'b0});
        @(posedge CLK); #1;
        req_we = 1'b1; req_addr = 32'h80; req_wdata = 32'h5A5A5A5A;
        check("bp busy req_ready", 32'(req_ready), 32'd0);
        @(negedge CLK);
        req_valid = 1'b0;
        @(posedge CLK); #1;
        check("bp load resp_valid", 32'(resp_valid), 32'd1);
        want = exp_q.pop_front();
        check("bp load rdata", resp_rdata, want.rdata);
        req_valid = 1'b1;
        @(posedge CLK); #1;
        check("bp idle req_ready", 32'(req_ready), 32'd1);
        check("bp store not yet", ram[32], 32'h0);
        @(posedge CLK); #1;
        check("bp accepted", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        @(posedge CLK); #1;
        check("bp store resp_valid", 32'(resp_valid), 32'd1);
        check("bp store rdata", resp_rdata, 32'h0);
        check("bp store ram", ram[32], 32'h5A5A5A5A);
        @(posedge CLK); #1;
        check("bp final ready", 32'(req_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit placed between the execute stage and the word-organised data RAM. Accepts one byte, halfword or word access per request, drives the RAM's word address, write enable and write data, and returns aligned, sign- or zero-extended load data. Sub-word stores are done as a registered read-modify-write, because the RAM only supports full-word writes. The RAM read path is combinational, and this block registers everything it presents to the core.

## Interface

Parameters:
- DEPTH, 1024: number of 32-bit words in the attached RAM.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents an access.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU. Other codes are illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, taken from the low byte/halfword/word.
- resp_valid  out  1  one-cycle pulse when the access completes.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  misaligned or illegal access; only driven when LSU_MISALIGN_TRAP_EN is defined.
- MemWrite  out  1  RAM write enable.
- mem_addr  out  $clog2(DEPTH)  RAM word index = req_addr[$clog2(DEPTH)+1:2]. Upper bits are dropped, so accesses wrap.
- write_data  out  32  RAM write word.
- read_data  in  32  RAM combinational read word.

## Operation

The state machine has four states:

- **IDLE**
  - req_ready=1.
  - On req_valid: latch we, funct3, addr and wdata, then go to ACCESS.
- **ACCESS**
  - mem_addr is driven from the latched address.
  - Load: extract the byte or halfword selected by addr[1:0], extend it (signed for B/H, unsigned for BU/HU), latch into resp_rdata, go to DONE.
  - Word store: MemWrite=1, write_data=wdata, go to DONE.
  - Sub-word store: merge wdata into the selected lane of read_data, latch the result into the merge register, go to WRITE.
- **WRITE**
  - MemWrite=1, write_data = merge register, then go to DONE.
- **DONE**
  - resp_valid=1 for exactly one cycle, then go to IDLE.

Further rules:
- MemWrite is 0 in every state other than those listed above.
- mem_addr holds its last value while in IDLE.
- Illegal funct3 for a store: 011, or any value with bit 2 set.
- Illegal funct3 for a load: 011, 110, 111.

## Timing

- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, MemWrite=0, mem_addr=0, write_data=0, merge register 0.
- Latency from the acceptance edge to resp_valid:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles.
- Throughput: one access in flight. The next acceptance is possible in the cycle after DONE.
- req_valid while req_ready=0 is ignored. The core must hold the request until it is accepted.
- resp_rdata and resp_err hold their value until the next DONE.
- Reset asserted mid-access returns to IDLE immediately and deasserts MemWrite. A partially completed RMW leaves the RAM unchanged, because the write happens only in WRITE.

## Configuration

- LSU_MISALIGN_TRAP_EN defined:
  - A misaligned access (H with addr[0]=1, W with addr[1:0]≠0) or an illegal funct3 skips ACCESS/WRITE and goes from IDLE straight to DONE.
  - resp_err=1, no MemWrite, resp_rdata=0.
- Not defined:
  - resp_err is tied to 0.
  - Address low bits are forced to natural alignment (H clears bit 0, W clears bits 1:0).
  - Illegal funct3 is treated as W.

## Structure

- lsu_pkg holds:
  - a funct3 encoding enum;
  - the state enum {IDLE, ACCESS, WRITE, DONE};
  - byte-lane constants.
- One sub-module, lsu_load_align, which is combinational: read word, addr[1:0] and funct3 in, extended 32-bit result out. The FSM and the store merge stay in load_store_unit.

## Test plan

- **Word store then load:** SW 0xDEADBEEF at 0x10, then LW at 0x10.
  - Store: MemWrite high for exactly one cycle with mem_addr=4.
  - Load: resp_rdata=0xDEADBEEF, resp_valid 2 cycles after acceptance.
- **Byte RMW:** with 0x11223344 at 0x20, SB 0xAA at 0x21.
  - The word becomes 0x1122AA44.
  - MemWrite is asserted only in WRITE, and resp_valid arrives 3 cycles after acceptance.
- **Extension:** with 0x8000FF80 at 0x30:
  - LB 0x30 → 0xFFFFFF80;
  - LBU 0x30 → 0x00000080;
  - LH 0x32 → 0xFFFF8000;
  - LHU 0x32 → 0x00008000.
- **Misalign:** LH at 0x41.
  - With the macro: resp_err=1, resp_rdata=0, no MemWrite.
  - Without the macro: data comes from 0x40 and resp_err=0.
- **Reset in WRITE:** assert RST_N=0 during the WRITE cycle of an SH.
  - MemWrite drops asynchronously and the RAM word is unchanged.
  - After release: req_ready=1, resp_valid=0.
- **Back-pressure:** toggle req_valid while busy.
  - It is ignored.
  - A request held from DONE is accepted in the following IDLE cycle.
